// File: rtl/rpn_stack_pkg.sv
// Shared definitions for the parametrised RPN operand stack: count-width helper
// and the operation codes produced by the per-cycle priority decoder.
package rpn_stack_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NONE    = 3'd0;
   localparam op_t OP_CLEAR   = 3'd1;
   localparam op_t OP_REPLACE = 3'd2;
   localparam op_t OP_PUSH    = 3'd3;
   localparam op_t OP_POP     = 3'd4;
   localparam op_t OP_PEEK    = 3'd5;

   // Bits needed to hold every occupancy value 0..depth inclusive.
   function automatic int clog2_depth(input int depth);
      int w;
      w = 1;
      while ((1 << w) <= depth) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rpn_param_stack.sv
// Parametrised LIFO operand stack. Entries at index >= count are always zero,
// so the top, next and snapshot views need no masking.
module rpn_param_stack
   import rpn_stack_pkg::*;
#(
   parameter  int DATA_WIDTH  = 4,
   parameter  int STACK_DEPTH = 4,
   localparam int CNT_WIDTH   = clog2_depth(STACK_DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              push,
   input  logic                              pop,
   input  logic                              peek,
   input  logic                              clear,
   input  logic [DATA_WIDTH-1:0]             dataIn,
   output logic [DATA_WIDTH-1:0]             dataOut,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             top,
   output logic [DATA_WIDTH-1:0]             next,
   output logic [CNT_WIDTH-1:0]              count,
   output logic                              empty,
   output logic                              full,
   output logic                              err_ovf,
   output logic                              err_unf,
   output logic [STACK_DEPTH*DATA_WIDTH-1:0] snapshot
);

   logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [STACK_DEPTH];
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  err_ovf_q, err_ovf_d;
   logic                  err_unf_q, err_unf_d;

   op_t                   op;
   logic                  is_empty;
   logic                  is_full;
   logic [DATA_WIDTH-1:0] top_w;
   logic [DATA_WIDTH-1:0] next_w;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_WIDTH'(STACK_DEPTH));

   // Priority decode: clear > replace > push > pop > peek; peek alongside push/pop is dropped.
   always_comb begin
      op = OP_NONE;
      if (clear) begin
         op = OP_CLEAR;
      end else if (push && pop) begin
         op = OP_REPLACE;
      end else if (push) begin
         op = OP_PUSH;
      end else if (pop) begin
         op = OP_POP;
      end else if (peek) begin
         op = OP_PEEK;
      end
   end

   // Select the entries at count-1 and count-2 for the top/next views.
   always_comb begin
      top_w  = '0;
      next_w = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (count_q == CNT_WIDTH'(i + 1)) begin
            top_w = mem_q[i];
         end
         if ((i + 2 <= STACK_DEPTH) && (count_q == CNT_WIDTH'(i + 2))) begin
            next_w = mem_q[i];
         end
      end
   end

   // Next-state for storage, occupancy, result register and sticky error flags.
   always_comb begin
      mem_d       = mem_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      err_ovf_d   = err_ovf_q;
      err_unf_d   = err_unf_q;
      case (op)
         OP_CLEAR: begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
               mem_d[i] = '0;
            end
            count_d   = '0;
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
         end
         OP_REPLACE: begin
            if (is_empty) begin
               err_unf_d = 1'b1;
            end else begin
               data_out_d  = top_w;
               out_valid_d = 1'b1;
               for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (count_q == CNT_WIDTH'(i + 1)) begin
                     mem_d[i] = dataIn;
                  end
               end
            end
         end
         OP_PUSH: begin
            if (is_full) begin
               err_ovf_d = 1'b1;
            end else begin
               for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (count_q == CNT_WIDTH'(i)) begin
                     mem_d[i] = dataIn;
                  end
               end
               count_d = count_q + CNT_WIDTH'(1);
            end
         end
         OP_POP: begin
            if (is_empty) begin
               err_unf_d = 1'b1;
            end else begin
               data_out_d  = top_w;
               out_valid_d = 1'b1;
               // Zero the vacated slot so entries above count stay zero.
               for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (count_q == CNT_WIDTH'(i + 1)) begin
                     mem_d[i] = '0;
                  end
               end
               count_d = count_q - CNT_WIDTH'(1);
            end
         end
         OP_PEEK: begin
            if (is_empty) begin
               err_unf_d = 1'b1;
            end else begin
               data_out_d  = top_w;
               out_valid_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // State registers; async reset zeroes everything so no partial write survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         count_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   for (genvar g = 0; g < STACK_DEPTH; g++) begin : g_snap
      assign snapshot[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
   end

   assign dataOut   = data_out_q;
   assign out_valid = out_valid_q;
   assign top       = top_w;
   assign next      = next_w;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign err_ovf   = err_ovf_q;
   assign err_unf   = err_unf_q;

endmodule

// File: doc/rpn_param_stack.md
Name: rpn_param_stack

Overview:
- Parametrised LIFO operand stack for the RPN calculator datapath. It is the next generation of the fixed 4x4 stack.
- Width and depth are generic.
- Adds these behaviours:
  - active-low async reset
  - clear
  - atomic replace-top (push+pop in one cycle)
  - registered pop/peek result with valid strobe
  - occupancy count and full/empty flags
  - sticky overflow/underflow errors
  - flat snapshot of all entries for display

Parameters:
- DATA_WIDTH, 4, bits per entry (>=1)
- STACK_DEPTH, 4, number of entries (>=2)
- CNT_WIDTH, $clog2(STACK_DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- push  in  1  push dataIn (with pop: replace top)
- pop  in  1  pop top entry
- peek  in  1  read top entry without removal
- clear  in  1  synchronous empty-and-zero of whole stack
- dataIn  in  DATA_WIDTH  operand to push/replace
- dataOut  out  DATA_WIDTH  registered result of pop/peek/replace
- out_valid  out  1  one-cycle strobe: dataOut updated this cycle
- top  out  DATA_WIDTH  combinational current top entry (0 when empty)
- next  out  DATA_WIDTH  combinational entry below top (0 when count<2)
- count  out  CNT_WIDTH  current occupancy, 0..STACK_DEPTH
- empty  out  1  count==0
- full  out  1  count==STACK_DEPTH
- err_ovf  out  1  sticky: push attempted while full
- err_unf  out  1  sticky: pop/peek/replace attempted while empty
- snapshot  out  STACK_DEPTH*DATA_WIDTH  entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]; slot 0 = bottom

Behaviour:
- Reset (rst_n=0, async): all entries=0, count=0, dataOut=0, out_valid=0, err_ovf=0, err_unf=0. Release is synchronous to clk; the first edge after release may carry an operation.
- Per-cycle decode, priority high to low:
  - clear
  - push&pop (replace)
  - push
  - pop
  - peek
- Peek asserted together with push or pop is ignored.
- out_valid defaults to 0 every cycle. dataOut holds its last value unless rewritten.
- clear: all entries=0, count=0, err_ovf=0, err_unf=0, out_valid=0. All other inputs are ignored that cycle.
- replace (push&pop):
  - If count>0: dataOut<=old top, out_valid<=1, entry[count-1]<=dataIn, count unchanged.
  - If empty: err_unf<=1, no state change.
- push:
  - If !full: entry[count]<=dataIn, count<=count+1.
  - If full: err_ovf<=1, contents unchanged (no wrap, no overwrite).
- pop:
  - If count>0: dataOut<=entry[count-1], out_valid<=1, entry[count-1]<=0, count<=count-1.
  - If empty: err_unf<=1, no change.
- peek:
  - If count>0: dataOut<=entry[count-1], out_valid<=1, count unchanged.
  - If empty: err_unf<=1.
- Latency:
  - dataOut/out_valid appear on the edge that performs the operation, i.e. they are visible in the following cycle.
  - top/next/count/flags/snapshot reflect post-edge state immediately (no extra cycle).
- Invariants:
  - Slots at index >= count always read 0.
  - count never exceeds STACK_DEPTH or underflows.
  - Error flags are cleared only by clear or reset.
- Reset asserted mid-operation: the async clear wins; any in-flight operation is lost, with no partial write.
- No input registering. Inputs are assumed synchronous to clk; debouncing/edge detection of buttons is done upstream.

Decomposition:
- Package rpn_stack_pkg holds:
  - function clog2_depth(depth), used to derive CNT_WIDTH
  - localparam op codes OP_NONE, OP_CLEAR, OP_REPLACE, OP_PUSH, OP_POP, OP_PEEK, used by the priority decoder and by the bench scoreboard
- No sub-module. A single always block for storage/count/flags plus combinational decode and output assigns fits comfortably.

Test Plan:
- Reset then push 0x3, 0x5, 0x9 (DEPTH=4, WIDTH=4) -> count=3, top=0x9, next=0x5, snapshot=0x0953, empty=0, full=0.
- From the above, push 0xA then push 0xF -> full=1, count=4, err_ovf=1, snapshot=0xA953 unchanged by 0xF.
- Pop twice -> out_valid pulses each cycle, dataOut=0xA then 0x9, count=2, snapshot=0x0053; peek -> dataOut=0x5, count stays 2.
- push&pop with dataIn=0xC at count=2 -> dataOut=0x5, out_valid=1, top=0xC, count=2; peek+push together -> treated as push only.
- Pop on empty stack -> err_unf=1, count=0, out_valid=0, dataOut unchanged; subsequent clear -> err_unf=0, err_ovf=0.
- Push 0x7 with rst_n pulsed low mid-cycle (between edges) -> all outputs 0 immediately; next edge with push 0x2 -> count=1, top=0x2.
